// File: rtl/clkdiv_dyn_multi.sv
// clkdiv_dyn_multi: multi-channel run-time programmable clock divider.
// Each channel divides clkin by div, stays high for duty cycles per period, and can be
// re-phased. Updates land on a period boundary, so a channel never emits a runt pulse.
//
// Config handshake: a transfer happens on a rising clkin edge when cfg_valid & cfg_ready
// are both 1. The requester holds cfg_valid and the fields stable until that edge.
// cfg_ready is 0 while an accepted update waits to be applied, and for one cycle after
// a request to a non-existent channel is dropped.
module clkdiv_dyn_multi #(
    parameter int NCH         = 4,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 16,
    parameter int LOCK_CYCLES = 64,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LOCK_W     = $clog2(LOCK_CYCLES + 1)
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_duty,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic [NCH-1:0]   clkout,
    output logic [NCH-1:0]   tick,
    output logic             lock
);

    // Per-channel configuration and counter state
    logic [DIV_W-1:0] div_q   [NCH];
    logic [DIV_W-1:0] div_d   [NCH];
    logic [DIV_W-1:0] duty_q  [NCH];
    logic [DIV_W-1:0] duty_d  [NCH];
    logic [DIV_W-1:0] cnt_q   [NCH];
    logic [DIV_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   clkout_q, clkout_d;
    logic [NCH-1:0]   tick_q, tick_d;

    // Single pending-update slot
    logic             pend_valid_q, pend_valid_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic [DIV_W-1:0] pend_duty_q, pend_duty_d;
    logic [DIV_W-1:0] pend_phase_q, pend_phase_d;
    logic             drop_q, drop_d;

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

    logic             accept;
    logic             ch_ok;
    logic             apply;
    logic [DIV_W-1:0] tgt_div, tgt_cnt;
    logic [DIV_W-1:0] c_div, c_duty, c_phase;

    assign cfg_ready = !(pend_valid_q || drop_q);
    assign clkout    = clkout_q;
    assign tick      = tick_q;
    assign lock      = (lock_cnt_q == LOCK_W'(LOCK_CYCLES));

    // Handshake decode, field clamping and apply-point detection
    always_comb begin
        accept  = cfg_valid && cfg_ready;
        ch_ok   = (int'(cfg_ch) < NCH);
        c_div   = (cfg_div == DIV_W'(1)) ? DIV_W'(2) : cfg_div;
        if (cfg_duty == '0)
            c_duty = c_div >> 1;
        else if (cfg_duty >= c_div)
            c_duty = c_div - DIV_W'(1);
        else
            c_duty = cfg_duty;
        c_phase = (cfg_phase >= c_div) ? '0 : cfg_phase;
        tgt_div = div_q[pend_ch_q];
        tgt_cnt = cnt_q[pend_ch_q];
        // A disabled target takes the update at once; a running one waits for its last count
        apply   = pend_valid_q &&
                  ((tgt_div == '0) || (tgt_cnt == tgt_div - DIV_W'(1)));
    end

    // Per-channel counters and registered clock/tick outputs
    always_comb begin
        clkout_d = '0;
        tick_d   = '0;
        for (int c = 0; c < NCH; c++) begin
            div_d[c]  = div_q[c];
            duty_d[c] = duty_q[c];
            cnt_d[c]  = '0;
            if (div_q[c] != '0) begin
                clkout_d[c] = (cnt_q[c] < duty_q[c]);
                tick_d[c]   = (cnt_q[c] == '0);
                cnt_d[c]    = (cnt_q[c] == div_q[c] - DIV_W'(1)) ? '0 : cnt_q[c] + DIV_W'(1);
            end
            // The update replaces the wrap, so the old period always completes
            if (apply && (pend_ch_q == CH_W'(c))) begin
                div_d[c]  = pend_div_q;
                duty_d[c] = pend_duty_q;
                cnt_d[c]  = pend_phase_q;
            end
        end
    end

    // Pending slot, drop flag and lock counter next state
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_ch_d    = pend_ch_q;
        pend_div_d   = pend_div_q;
        pend_duty_d  = pend_duty_q;
        pend_phase_d = pend_phase_q;
        drop_d       = 1'b0;
        if (apply)
            pend_valid_d = 1'b0;
        if (accept) begin
            if (ch_ok) begin
                pend_valid_d = 1'b1;
                pend_ch_d    = cfg_ch;
                pend_div_d   = c_div;
                pend_duty_d  = c_duty;
                pend_phase_d = c_phase;
            end else begin
                drop_d = 1'b1;
            end
        end
        if (apply)
            lock_cnt_d = '0;
        else if (lock_cnt_q != LOCK_W'(LOCK_CYCLES))
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        else
            lock_cnt_d = lock_cnt_q;
    end

    // State registers; reset drops any pending update and restores defaults
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                div_q[c]  <= DIV_W'(DEF_DIV);
                duty_q[c] <= DIV_W'(DEF_DIV >> 1);
                cnt_q[c]  <= '0;
            end
            clkout_q     <= '0;
            tick_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_div_q   <= '0;
            pend_duty_q  <= '0;
            pend_phase_q <= '0;
            drop_q       <= 1'b0;
            lock_cnt_q   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                div_q[c]  <= div_d[c];
                duty_q[c] <= duty_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            clkout_q     <= clkout_d;
            tick_q       <= tick_d;
            pend_valid_q <= pend_valid_d;
            pend_ch_q    <= pend_ch_d;
            pend_div_q   <= pend_div_d;
            pend_duty_q  <= pend_duty_d;
            pend_phase_q <= pend_phase_d;
            drop_q       <= drop_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_dyn_multi.sv
// Directed bench for clkdiv_dyn_multi. Cycle k counts rising edges after reset release;
// outputs are sampled 1 time unit after each edge. A second instance with NCH=5 has a
// 3-bit channel field, so it can be sent a request for a channel that does not exist.
module tb_clkdiv_dyn_multi;

    logic       clkin = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_valid5;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_div, cfg_duty, cfg_phase;
    logic       cfg_ready, cfg_ready5;
    logic [3:0] clkout, tick;
    logic [4:0] clkout5, tick5;
    logic       lock, lock5;

    int cyc;
    int n_checks;
    int n_errors;

    clkdiv_dyn_multi u_dut (
        .clkin     (clkin),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch[1:0]),
        .cfg_div   (cfg_div),
        .cfg_duty  (cfg_duty),
        .cfg_phase (cfg_phase),
        .clkout    (clkout),
        .tick      (tick),
        .lock      (lock)
    );

    clkdiv_dyn_multi #(.NCH(5)) u_dut5 (
        .clkin     (clkin),
        .reset     (reset),
        .cfg_valid (cfg_valid5),
        .cfg_ready (cfg_ready5),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_duty  (cfg_duty),
        .cfg_phase (cfg_phase),
        .clkout    (clkout5),
        .tick      (tick5),
        .lock      (lock5)
    );

    // Clock
    always #5 clkin = ~clkin;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic drive_cfg(input logic [2:0] ch, input logic [7:0] dv,
                             input logic [7:0] dt, input logic [7:0] ph);
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_duty  = dt;
        cfg_phase = ph;
        cfg_valid = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_valid5 = 1'b0;
        cfg_ch     = '0;
        cfg_div    = '0;
        cfg_duty   = '0;
        cfg_phase  = '0;
        cyc        = 0;
        n_checks   = 0;
        n_errors   = 0;

        repeat (3) @(posedge clkin);
        #1;
        check_eq("rst_clkout", 32'(clkout), 32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        check_eq("rst_lock", 32'(lock), 32'h0);
        check_eq("rst_ready", 32'(cfg_ready), 32'h1);
        reset = 1'b0;
        cyc   = 0;

        // 1: defaults, period 16 / 8 high, first tick one cycle after release, lock at 64
        for (int k = 1; k <= 64; k++) begin
            step();
            check_eq("def_clkout", 32'(clkout), (((k - 1) % 16) < 8) ? 32'hf : 32'h0);
            check_eq("def_tick", 32'(tick), (((k - 1) % 16) == 0) ? 32'hf : 32'h0);
            if (k == 63) check_eq("lock_63", 32'(lock), 32'h0);
            if (k == 64) check_eq("lock_64", 32'(lock), 32'h1);
        end
        check_eq("lock5_64", 32'(lock5), 32'h1);

        // 2: ch1 div=5 duty=0 mid-period; old period completes, applies at 80
        run_to(70);
        drive_cfg(3'd1, 8'd5, 8'd0, 8'd0);
        step();
        cfg_valid = 1'b0;
        check_eq("w1_ready_lo", 32'(cfg_ready), 32'h0);
        for (int k = 72; k <= 95; k++) begin
            step();
            if (k <= 80) begin
                check_eq("ch1_old_clk", 32'(clkout[1]), 32'(((k - 1) % 16) < 8));
                check_eq("ch1_old_tick", 32'(tick[1]), 32'(((k - 1) % 16) == 0));
            end else begin
                check_eq("ch1_new_clk", 32'(clkout[1]), 32'(((k - 81) % 5) < 2));
                check_eq("ch1_new_tick", 32'(tick[1]), 32'(((k - 81) % 5) == 0));
            end
            check_eq("ch0_undisturbed", 32'(clkout[0]), 32'(((k - 1) % 16) < 8));
            if (k == 79) begin
                check_eq("w1_ready_79", 32'(cfg_ready), 32'h0);
                check_eq("w1_lock_79", 32'(lock), 32'h1);
            end
            if (k == 80) begin
                check_eq("w1_ready_80", 32'(cfg_ready), 32'h1);
                check_eq("w1_lock_80", 32'(lock), 32'h0);
            end
        end
        run_to(143);
        check_eq("relock_143", 32'(lock), 32'h0);
        step();
        check_eq("relock_144", 32'(lock), 32'h1);

        // 3: disable ch2 at its boundary (160), then re-enable with duty clamp
        drive_cfg(3'd2, 8'd0, 8'd0, 8'd0);
        step();
        cfg_valid = 1'b0;
        check_eq("w2_ready_lo", 32'(cfg_ready), 32'h0);
        run_to(150);
        check_eq("ch2_running", 32'(clkout[2]), 32'h1);
        run_to(160);
        check_eq("w2_ready_160", 32'(cfg_ready), 32'h1);
        check_eq("ch2_last_low", 32'(clkout[2]), 32'h0);
        for (int k = 161; k <= 170; k++) begin
            step();
            check_eq("ch2_off", 32'({clkout[2], tick[2]}), 32'h0);
        end
        drive_cfg(3'd2, 8'd3, 8'd7, 8'd0);
        step();
        cfg_valid = 1'b0;
        check_eq("w3_ready_171", 32'(cfg_ready), 32'h0);
        step();
        check_eq("w3_ready_172", 32'(cfg_ready), 32'h1);
        check_eq("ch2_still_off", 32'(clkout[2]), 32'h0);
        for (int k = 173; k <= 181; k++) begin
            step();
            check_eq("ch2_div3_clk", 32'(clkout[2]), 32'(((k - 173) % 3) < 2));
            check_eq("ch2_div3_tick", 32'(tick[2]), 32'(((k - 173) % 3) == 0));
        end

        // 4: ch3 div=16 phase=4, applied at 192; ch3 ticks 12 cycles after ch0
        drive_cfg(3'd3, 8'd16, 8'd0, 8'd4);
        step();
        cfg_valid = 1'b0;
        run_to(192);
        for (int k = 193; k <= 224; k++) begin
            step();
            check_eq("ch0_tick", 32'(tick[0]), 32'(((k - 1) % 16) == 0));
            check_eq("ch3_phase_tick", 32'(tick[3]), 32'(((k - 189) % 16) == 0));
            check_eq("ch3_phase_clk", 32'(clkout[3]), 32'(((k - 189) % 16) < 8));
        end

        // 5: back-to-back writes with cfg_valid held; second waits for the first apply
        drive_cfg(3'd0, 8'd4, 8'd0, 8'd0);
        step();
        check_eq("b2b_ready_225", 32'(cfg_ready), 32'h0);
        drive_cfg(3'd1, 8'd6, 8'd3, 8'd0);
        for (int k = 226; k <= 257; k++) begin
            step();
            if (k == 241) cfg_valid = 1'b0;
            check_eq("b2b_ready", 32'(cfg_ready),
                     32'((k == 240) || (k >= 245)));
            if (k <= 240)
                check_eq("b2b_ch0_old", 32'(clkout[0]), 32'(((k - 1) % 16) < 8));
            else
                check_eq("b2b_ch0_new", 32'({clkout[0], tick[0]}),
                         32'({(((k - 241) % 4) < 2), (((k - 241) % 4) == 0)}));
            if (k <= 245)
                check_eq("b2b_ch1_old", 32'(clkout[1]), 32'(((k - 81) % 5) < 2));
            else
                check_eq("b2b_ch1_new", 32'({clkout[1], tick[1]}),
                         32'({(((k - 246) % 6) < 3), (((k - 246) % 6) == 0)}));
        end

        // Dropped request to channel 7 on the 5-channel instance
        cfg_ch     = 3'd7;
        cfg_div    = 8'd3;
        cfg_valid5 = 1'b1;
        step();
        cfg_valid5 = 1'b0;
        check_eq("drop_ready_lo", 32'(cfg_ready5), 32'h0);
        check_eq("drop_lock_a", 32'(lock5), 32'h1);
        step();
        check_eq("drop_ready_hi", 32'(cfg_ready5), 32'h1);
        check_eq("drop_lock_b", 32'(lock5), 32'h1);
        check_eq("drop_clk5", 32'(clkout5), 32'h1f);
        run_to(273);
        check_eq("drop_tick5", 32'(tick5), 32'h1f);
        check_eq("drop_lock_c", 32'(lock5), 32'h1);

        // 6: reset while a ch3 update is pending (it would apply at 284)
        drive_cfg(3'd3, 8'd7, 8'd0, 8'd0);
        step();
        cfg_valid = 1'b0;
        check_eq("pend_ready_lo", 32'(cfg_ready), 32'h0);
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_clkout", 32'(clkout), 32'h0);
        check_eq("mid_rst_tick", 32'(tick), 32'h0);
        check_eq("mid_rst_lock", 32'(lock), 32'h0);
        check_eq("mid_rst_ready", 32'(cfg_ready), 32'h1);
        repeat (2) @(posedge clkin);
        #1;
        reset = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            check_eq("post_rst_clkout", 32'(clkout), (((k - 1) % 16) < 8) ? 32'hf : 32'h0);
            check_eq("post_rst_tick", 32'(tick), (((k - 1) % 16) == 0) ? 32'hf : 32'h0);
            check_eq("post_rst_ready", 32'(cfg_ready), 32'h1);
        end
        check_eq("post_rst_lock", 32'(lock), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
